// File: rtl/wb_progress_slave_if.sv
// Wishbone slave-side bundle for the progress/scratch block.
// Signal names follow the Caravel user-project Wishbone naming.
interface wb_progress_slave_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_progress_slave.sv
// Wishbone slave: progress/done pads for DV, scratch RAM,
// and a RAM write counter plus checksum for firmware self-checks.
module wb_progress_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          MEM_WORDS   = 64,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h5742_0001,
  parameter int          WCOUNT_W    = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_progress_slave_if.slave  wb,
  output logic [37:0]         io_out,
  output logic [37:0]         io_oeb
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [31:0]         r_dat;
  logic [5:0]          r_prog;
  logic [1:0]          r_done;
  logic [WCOUNT_W-1:0] r_wcnt;
  logic [31:0]         r_csum;
  logic [31:0]         r_mem [2**AW];

  logic        w_cs;
  logic        w_sel;
  logic [11:0] w_off;
  logic [AW-1:0] w_idx;
  logic        w_ram_hit;
  logic        w_commit;
  logic [31:0] w_mask;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_cs  = wb.wbs_cyc_i & wb.wbs_stb_i;
  assign w_sel = w_cs &
    (wb.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign w_off = wb.wbs_adr_i[11:0];
  assign w_idx = w_off[AW+1:2];
  assign w_ram_hit = (w_off[11:8] == 4'h1) &&
    ({26'd0, w_off[7:2]} < 32'(MEM_WORDS));
  assign w_commit = (r_state == S_ACK) && wb.wbs_we_i;
  assign w_mask = {{8{wb.wbs_sel_i[3]}},
                   {8{wb.wbs_sel_i[2]}},
                   {8{wb.wbs_sel_i[1]}},
                   {8{wb.wbs_sel_i[0]}}};
  assign w_unused = &{1'b0, w_off};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_sel)
          w_next = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
      S_WAIT:
        if (!w_cs) w_next = S_IDLE;
        else if (r_cnt <= 4'd1) w_next = S_ACK;
      S_ACK: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    if (w_ram_hit) begin
      w_rdata = r_mem[w_idx];
    end else begin
      case (w_off[11:2])
        10'h000: w_rdata = ID_VALUE;
        10'h001: w_rdata = {26'd0, r_prog};
        10'h002: w_rdata = {30'd0, r_done};
        10'h003: w_rdata = 32'(r_wcnt);
        10'h004: w_rdata = r_csum;
        default: w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dat   <= '0;
      r_prog  <= '0;
      r_done  <= '0;
      r_wcnt  <= '0;
      r_csum  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) r_cnt <= 4'(WAIT_STATES);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
      r_dat <= (w_next == S_ACK) ? w_rdata : '0;
      if (w_commit) begin
        if (w_off[11:2] == 10'h001 && wb.wbs_sel_i[0])
          r_prog <= wb.wbs_dat_i[5:0];
        if (w_off[11:2] == 10'h002 && wb.wbs_sel_i[0])
          r_done <= wb.wbs_dat_i[1:0];
        if (w_off[11:2] == 10'h004) begin
          r_wcnt <= '0;
          r_csum <= '0;
        end
        if (w_ram_hit) begin
          if (r_wcnt != '1) r_wcnt <= r_wcnt + 1'b1;
          r_csum <= r_csum + (wb.wbs_dat_i & w_mask);
        end
      end
    end
  end

  // Scratch RAM is deliberately left unreset
  always_ff @(posedge wb_clk_i) begin
    if (w_commit && w_ram_hit) begin
      for (int b = 0; b < 4; b++)
        if (wb.wbs_sel_i[b])
          r_mem[w_idx][8*b +: 8] <= wb.wbs_dat_i[8*b +: 8];
    end
  end

  assign wb.wbs_ack_o = (r_state == S_ACK);
  assign wb.wbs_dat_o = r_dat;
  assign io_out = {r_done, 10'd0, r_prog, 20'd0};
  assign io_oeb = {2'b00, 10'h3FF, 6'd0, 20'hFFFFF};

endmodule
